// File: rtl/audio_buf_ctrl.sv
// Ping-pong refill controller for the 512-byte I2S sample RAM.
// Define AUDIO_BUF_UF_CNT_EN to build the saturating underrun counter.
module audio_buf_ctrl #(
  parameter int ADDR_W      = 9,
  parameter int SYNC_STAGES = 2
) (
  input  logic              iclk,
  input  logic              rst,
  input  logic              play,
  input  logic [7:0]        src_data,
  input  logic              src_valid,
  output logic              src_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  input  logic              rd_half,
  output logic              en,
  input  logic              clr_underrun,
  output logic              underrun,
  output logic [15:0]       uf_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WAIT
  } state_t;

  state_t              state_q, state_d;
  logic                fill_half_q, fill_half_d;
  logic [ADDR_W-2:0]   cnt_q, cnt_d;
  logic                primed_q, primed_d;
  logic                en_q, en_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                rd_half_s;
  logic                accept;
  logic                uf_cond, uf_cond_q, uf_rise;

  assign rd_half_s = sync_q[SYNC_STAGES-1];
  assign src_ready = (state_q == FILL);
  assign accept    = src_valid && src_ready;
  assign en        = en_q;

  // Underrun: the reader is inside the half still being refilled.
  assign uf_cond = (state_q == FILL) && en_q
                && (rd_half_s == fill_half_q);
  assign uf_rise = uf_cond && !uf_cond_q;

  always_comb begin
    state_d     = state_q;
    fill_half_d = fill_half_q;
    cnt_d       = cnt_q;
    primed_d    = primed_q;
    en_d        = en_q;
    unique case (state_q)
      IDLE: begin
        en_d = 1'b0;
        if (play) begin
          state_d     = FILL;
          fill_half_d = 1'b0;
          cnt_d       = '0;
          primed_d    = 1'b0;
        end
      end
      FILL: begin
        if (!play) begin
          state_d = IDLE;
          en_d    = 1'b0;
        end else if (accept) begin
          cnt_d = cnt_q + 1'b1;
          if (&cnt_q) begin
            unique case (1'b1)
              !primed_q && !fill_half_q: begin
                fill_half_d = 1'b1;
              end
              !primed_q && fill_half_q: begin
                primed_d    = 1'b1;
                en_d        = 1'b1;
                fill_half_d = 1'b0;
                state_d     = WAIT;
              end
              primed_q: begin
                fill_half_d = ~fill_half_q;
                state_d     = WAIT;
              end
            endcase
          end
        end
      end
      WAIT: begin
        if (!play) begin
          state_d = IDLE;
          en_d    = 1'b0;
        end else if (rd_half_s != fill_half_q) begin
          state_d = FILL;
        end
      end
      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge iclk) begin
    if (rst) begin
      state_q     <= IDLE;
      fill_half_q <= 1'b0;
      cnt_q       <= '0;
      primed_q    <= 1'b0;
      en_q        <= 1'b0;
      sync_q      <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      uf_cond_q   <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_half_q <= fill_half_d;
      cnt_q       <= cnt_d;
      primed_q    <= primed_d;
      en_q        <= en_d;
      sync_q      <= {sync_q[SYNC_STAGES-2:0], rd_half};
      wr_en       <= accept;
      if (accept) begin
        wr_addr <= {fill_half_q, cnt_q};
        wr_data <= src_data;
      end
      uf_cond_q <= uf_cond;
      if (uf_rise) begin
        underrun <= 1'b1;
      end else if (clr_underrun) begin
        underrun <= 1'b0;
      end
    end
  end

`ifdef AUDIO_BUF_UF_CNT_EN
  logic [15:0] uf_cnt_q;

  always_ff @(posedge iclk) begin
    if (rst) begin
      uf_cnt_q <= '0;
    end else if (uf_rise && (uf_cnt_q != 16'hFFFF)) begin
      uf_cnt_q <= uf_cnt_q + 16'd1;
    end
  end

  assign uf_cnt = uf_cnt_q;
`else
  assign uf_cnt = '0;
`endif

endmodule

// File: tb/tb_audio_buf_ctrl.sv
// Directed bench for audio_buf_ctrl with a write scoreboard.
// Inputs change at posedge+1; outputs are sampled on the negedge.
module tb_audio_buf_ctrl;

  localparam int AW = 9;
`ifdef AUDIO_BUF_UF_CNT_EN
  localparam int UF = 1;
`else
  localparam int UF = 0;
`endif

  logic          iclk = 1'b0;
  logic          rst = 1'b1;
  logic          play = 1'b0;
  logic [7:0]    src_data = 8'h00;
  logic          src_valid = 1'b0;
  logic          src_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          rd_half = 1'b0;
  logic          en;
  logic          clr_underrun = 1'b0;
  logic          underrun;
  logic [15:0]   uf_cnt;

  audio_buf_ctrl #(.ADDR_W(AW), .SYNC_STAGES(2)) dut (
    .iclk         (iclk),
    .rst          (rst),
    .play         (play),
    .src_data     (src_data),
    .src_valid    (src_valid),
    .src_ready    (src_ready),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .rd_half      (rd_half),
    .en           (en),
    .clr_underrun (clr_underrun),
    .underrun     (underrun),
    .uf_cnt       (uf_cnt)
  );

  always #5 iclk = ~iclk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  wr_t           sb[$];
  logic [AW-1:0] exp_addr = '0;
  int            tests = 0;
  int            fails = 0;
  bit            stall = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge iclk);
    #1;
    src_data = 8'($urandom);
    if (stall) src_valid = 1'($urandom_range(0, 1));
  endtask

  // Pop a write expectation or record an accept; runs each negedge.
  task automatic sample();
    wr_t e;
    @(negedge iclk);
    if (wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        chk("wr_spurious", 32'(wr_addr), 32'hFFFF);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e.addr));
        chk("wr_data", 32'(wr_data), 32'(e.data));
      end
    end
    if (!rst && src_valid && (src_ready === 1'b1)) begin
      sb.push_back('{addr: exp_addr, data: src_data});
      exp_addr = exp_addr + 1'b1;
    end
  endtask

  task automatic cyc();
    step();
    sample();
  endtask

  // Counts accepts starting with the current sample point.
  task automatic run_acc(input int target, input string tag);
    int n = 0;
    for (int i = 0; i < 4000; i++) begin
      if (src_valid && (src_ready === 1'b1)) n++;
      if (n >= target) break;
      cyc();
    end
    chk(tag, 32'(n), 32'(target));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, 32'(src_ready), 0);
    chk({tag, "_wr_en"}, 32'(wr_en), 0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 0);
    chk({tag, "_wr_data"}, 32'(wr_data), 0);
    chk({tag, "_en"}, 32'(en), 0);
    chk({tag, "_underrun"}, 32'(underrun), 0);
    chk({tag, "_uf_cnt"}, 32'(uf_cnt), 0);
  endtask

  initial begin
    int k;
    repeat (3) step();
    rst = 1'b0;
    sample();
    chk_reset("rst0");

    // Priming: 512 bytes with valid held high.
    step();
    play = 1'b1;
    src_valid = 1'b1;
    sample();
    chk("idle_ready", 32'(src_ready), 0);
    run_acc(512, "prime_cnt");
    chk("prime_en_pre", 32'(en), 0);
    cyc();
    chk("prime_en", 32'(en), 1);
    chk("prime_ready", 32'(src_ready), 0);
    repeat (5) cyc();
    chk("prime_hold", 32'(src_ready), 0);

    // Reader moves to half 1: refill half 0 after sync latency.
    step();
    rd_half = 1'b1;
    sample();
    k = 0;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      k = i;
      if (src_ready === 1'b1) break;
    end
    chk("wait_lat", 32'(k), 3);
    run_acc(256, "h0_cnt");
    cyc();
    chk("h0_done", 32'(src_ready), 0);
    repeat (5) cyc();
    chk("h1_wait", 32'(src_ready), 0);

    // Reader back to half 0: refill half 1 with random stalls.
    step();
    rd_half = 1'b0;
    stall = 1'b1;
    sample();
    run_acc(256, "h1_cnt");
    step();
    stall = 1'b0;
    src_valid = 1'b0;
    sample();
    repeat (4) cyc();
    chk("h0_wait", 32'(src_ready), 0);

    // Underrun: reader re-enters the half being filled.
    step();
    rd_half = 1'b1;
    sample();
    repeat (6) cyc();
    chk("uf_fill", 32'(src_ready), 1);
    chk("uf_none", 32'(underrun), 0);
    step();
    rd_half = 1'b0;
    sample();
    repeat (5) cyc();
    chk("uf1_flag", 32'(underrun), 1);
    chk("uf1_cnt", 32'(uf_cnt), 32'(UF * 1));
    step();
    rd_half = 1'b1;
    sample();
    repeat (5) cyc();
    step();
    rd_half = 1'b0;
    sample();
    repeat (5) cyc();
    chk("uf2_flag", 32'(underrun), 1);
    chk("uf2_cnt", 32'(uf_cnt), 32'(UF * 2));
    step();
    clr_underrun = 1'b1;
    sample();
    step();
    clr_underrun = 1'b0;
    sample();
    cyc();
    chk("clr_flag", 32'(underrun), 0);
    chk("clr_cnt", 32'(uf_cnt), 32'(UF * 2));

    // Clear coinciding with a new underrun edge: set wins.
    step();
    rd_half = 1'b1;
    sample();
    repeat (5) cyc();
    step();
    rd_half = 1'b0;
    sample();
    cyc();
    step();
    clr_underrun = 1'b1;
    sample();
    chk("setwin_pre", 32'(underrun), 0);
    step();
    clr_underrun = 1'b0;
    sample();
    chk("setwin_flag", 32'(underrun), 1);
    chk("setwin_cnt", 32'(uf_cnt), 32'(UF * 3));
    chk("uf_still_fill", 32'(src_ready), 1);

    // Drop play after 100 bytes; the beat in that cycle is kept.
    step();
    src_valid = 1'b1;
    sample();
    run_acc(100, "part_cnt");
    step();
    play = 1'b0;
    sample();
    cyc();
    chk("stop_en", 32'(en), 0);
    chk("stop_ready", 32'(src_ready), 0);
    repeat (3) cyc();
    chk("stop_sb", 32'(sb.size()), 0);
    step();
    play = 1'b1;
    exp_addr = '0;
    sample();
    run_acc(512, "restart_cnt");
    chk("restart_en_pre", 32'(en), 0);
    cyc();
    chk("restart_en", 32'(en), 1);

    // Reset in the middle of a fill.
    step();
    rd_half = 1'b1;
    sample();
    run_acc(50, "rstfill_cnt");
    step();
    rst = 1'b1;
    sample();
    step();
    sample();
    chk_reset("rst1");
    step();
    rst = 1'b0;
    play = 1'b0;
    src_valid = 1'b0;
    sample();
    cyc();
    chk("final_sb", 32'(sb.size()), 0);
    chk("final_wr_en", 32'(wr_en), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
